// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bus between an initiator and mem_responder
interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  modport master (output req_valid, req_write, req_size, req_addr, req_wdata,
                  input req_ready, rsp_valid, rsp_rdata, rsp_err);
  modport slave (input req_valid, req_write, req_size, req_addr, req_wdata,
                 output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

// File: rtl/mem_responder.sv
// mem_responder: big-endian byte-array memory with fixed-latency request/response handshake
// Define MEM_RESPONDER_ALIGN_CHECK_EN to reject misaligned halfword/word accesses.
module mem_responder #(
  parameter int WAIT_CYCLES = 1,
  parameter int MEM_BYTES   = 256
) (
  input logic clk,
  input logic reset,
  mem_responder_if.slave bus
);
  localparam int AW = $clog2(MEM_BYTES);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [2:0] cnt;
  logic wr_q;
  logic [1:0] size_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic err_q;
  logic [7:0] mem [MEM_BYTES];
  logic acc, s_wr, err;
  logic [1:0] s_size;
  logic [31:0] s_addr, ld;
  logic [32:0] last;
  logic [AW-1:0] ia;
  logic [7:0] b0, b1, b2, b3;
  assign acc = state == IDLE && bus.req_valid;
  assign bus.req_ready = state == IDLE;
  assign bus.rsp_valid = state == RESP;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err = err_q;
  always_comb begin
    state_nx = state == IDLE ? (bus.req_valid ? (WAIT_CYCLES == 0 ? RESP : WAIT) : IDLE) :
               state == WAIT ? (cnt == 3'd0 ? RESP : WAIT) : IDLE;
  end
  // With zero wait cycles the response is latched on the accepting edge, so decode the live request then
  always_comb begin
    s_wr = state == IDLE ? bus.req_write : wr_q;
    s_size = state == IDLE ? bus.req_size : size_q;
    s_addr = state == IDLE ? bus.req_addr : addr_q;
    last = {1'b0, s_addr} + (s_size == 2'd0 ? 33'd0 : s_size == 2'd1 ? 33'd1 : 33'd3);
    err = s_size == 2'd3 || last >= 33'(MEM_BYTES);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    err = err || (s_size == 2'd1 && s_addr[0]) || (s_size == 2'd2 && s_addr[1:0] != 2'd0);
`else
    err = err;
`endif
    ia = s_addr[AW-1:0];
    b0 = mem[ia];
    b1 = mem[ia + AW'(1)];
    b2 = mem[ia + AW'(2)];
    b3 = mem[ia + AW'(3)];
    ld = s_size == 2'd0 ? {24'd0, b0} : s_size == 2'd1 ? {16'd0, b0, b1} : {b0, b1, b2, b3};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= 3'd0;
      wr_q <= 1'b0;
      size_q <= 2'd0;
      addr_q <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (acc) begin
        wr_q <= bus.req_write;
        size_q <= bus.req_size;
        addr_q <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        cnt <= WAIT_CYCLES > 0 ? 3'(WAIT_CYCLES - 1) : 3'd0;
      end else if (state == WAIT && cnt != 3'd0) begin
        cnt <= cnt - 3'd1;
      end
      if (state_nx == RESP && state != RESP) begin
        err_q <= err;
        rdata_q <= (err || s_wr) ? 32'd0 : ld;
      end
    end
  end
  // Array is never reset; a store commits only on the edge leaving RESP
  always_ff @(posedge clk) begin
    if (!reset && state == RESP && wr_q && !err_q) begin
      mem[addr_q[AW-1:0]] <= size_q == 2'd0 ? wdata_q[7:0] : size_q == 2'd1 ? wdata_q[15:8] : wdata_q[31:24];
      if (size_q != 2'd0) mem[addr_q[AW-1:0] + AW'(1)] <= size_q == 2'd1 ? wdata_q[7:0] : wdata_q[23:16];
      if (size_q == 2'd2) begin
        mem[addr_q[AW-1:0] + AW'(2)] <= wdata_q[15:8];
        mem[addr_q[AW-1:0] + AW'(3)] <= wdata_q[7:0];
      end
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: table-driven checks of mem_responder plus reset-abort sequence
module tb_mem_responder;
  localparam int W = 1;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  mem_responder_if bus();
  mem_responder #(.WAIT_CYCLES(W), .MEM_BYTES(256)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  typedef struct {
    string       name;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;
  vec_t tv[$];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask
  task automatic issue(input vec_t t);
    int n;
    logic seen;
    @(negedge clk);
    check({t.name, "_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_write = t.wr;
    bus.req_size = t.size;
    bus.req_addr = t.addr;
    bus.req_wdata = t.wdata;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_write = ~t.wr;
    bus.req_size = ~t.size;
    bus.req_addr = 32'hFFFF_FFF0;
    bus.req_wdata = ~t.wdata;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 16) begin
      @(negedge clk);
      n++;
      seen = bus.rsp_valid;
    end
    check({t.name, "_latency"}, 32'(n), 32'(W + 1));
    check({t.name, "_rdata"}, bus.rsp_rdata, t.rdata);
    check({t.name, "_err"}, 32'(bus.rsp_err), 32'(t.err));
    check({t.name, "_busy"}, 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    check({t.name, "_pulse"}, 32'(bus.rsp_valid), 32'd0);
    check({t.name, "_hold"}, bus.rsp_rdata, t.rdata);
  endtask
  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_size = 2'd0;
    bus.req_addr = 32'd0;
    bus.req_wdata = 32'd0;
    tv.push_back('{"st_w10", 1'b1, 2'd2, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0});
    tv.push_back('{"ld_w10", 1'b0, 2'd2, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0});
    tv.push_back('{"st_b11", 1'b1, 2'd0, 32'h11, 32'hFFFF_FF55, 32'h0, 1'b0});
    tv.push_back('{"ld_w10b", 1'b0, 2'd2, 32'h10, 32'h0, 32'hDE55_BEEF, 1'b0});
    tv.push_back('{"ld_h12", 1'b0, 2'd1, 32'h12, 32'h0, 32'h0000_BEEF, 1'b0});
    tv.push_back('{"ld_w253", 1'b0, 2'd2, 32'd253, 32'h0, 32'h0, 1'b1});
    tv.push_back('{"st_b255", 1'b1, 2'd0, 32'd255, 32'h0000_00A5, 32'h0, 1'b0});
    tv.push_back('{"ld_b255", 1'b0, 2'd0, 32'd255, 32'h0, 32'h0000_00A5, 1'b0});
    tv.push_back('{"st_w252", 1'b1, 2'd2, 32'd252, 32'h1122_3344, 32'h0, 1'b0});
    tv.push_back('{"st_w100", 1'b1, 2'd2, 32'h100, 32'hCAFE_F00D, 32'h0, 1'b1});
    tv.push_back('{"ld_w252", 1'b0, 2'd2, 32'd252, 32'h0, 32'h1122_3344, 1'b0});
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    tv.push_back('{"ld_h11", 1'b0, 2'd1, 32'h11, 32'h0, 32'h0, 1'b1});
`else
    tv.push_back('{"ld_h11", 1'b0, 2'd1, 32'h11, 32'h0, 32'h0000_55BE, 1'b0});
`endif
    tv.push_back('{"ld_sz3", 1'b0, 2'd3, 32'h10, 32'h0, 32'h0, 1'b1});
    tv.push_back('{"st_sz3", 1'b1, 2'd3, 32'h10, 32'hFFFF_FFFF, 32'h0, 1'b1});
    tv.push_back('{"ld_w10c", 1'b0, 2'd2, 32'h10, 32'h0, 32'hDE55_BEEF, 1'b0});
    tv.push_back('{"ld_wrap", 1'b0, 2'd2, 32'hFFFF_FFFE, 32'h0, 32'h0, 1'b1});
    tv.push_back('{"st_w20z", 1'b1, 2'd2, 32'h20, 32'h0, 32'h0, 1'b0});
    tv.push_back('{"ld_w10d", 1'b0, 2'd2, 32'h10, 32'h0, 32'hDE55_BEEF, 1'b0});
    #1;
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    check("rst_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rdata", bus.rsp_rdata, 32'd0);
    check("rst_err", 32'(bus.rsp_err), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    foreach (tv[i]) issue(tv[i]);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_size = 2'd2;
    bus.req_addr = 32'h20;
    bus.req_wdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check("abort_busy", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_ready", 32'(bus.req_ready), 32'd1);
    check("abort_valid", 32'(bus.rsp_valid), 32'd0);
    check("abort_rdata", bus.rsp_rdata, 32'd0);
    check("abort_err", 32'(bus.rsp_err), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    issue('{"ld_w20", 1'b0, 2'd2, 32'h20, 32'h0, 32'h0, 1'b0});
    issue('{"ld_w10e", 1'b0, 2'd2, 32'h10, 32'h0, 32'hDE55_BEEF, 1'b0});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 1, wait cycles between request acceptance and response (range 0..7).
REQ-002 Parameter MEM_BYTES, default 256, byte capacity of the internal array; legal byte addresses 0..MEM_BYTES-1.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  initiator presents a request this cycle.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_size  input  2  access size: 00 byte, 01 halfword, 10 word; 11 illegal.
REQ-009 req_addr  input  32  byte address from the CPU memory-address selector.
REQ-010 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 rsp_valid  output  1  one-cycle pulse marking the response.
REQ-012 rsp_rdata  output  32  load data, right-aligned, zero-extended; 0 for stores and errors.
REQ-013 rsp_err  output  1  qualified by rsp_valid; request was rejected.

Function
REQ-014 FSM states IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-015 Handshake: request accepted on a rising edge with req_valid=1 and req_ready=1; req_write, req_size, req_addr, req_wdata captured into internal registers at that edge.
REQ-016 IDLE->WAIT on acceptance when WAIT_CYCLES>0; IDLE->RESP when WAIT_CYCLES=0.
REQ-017 WAIT holds a down-counter loaded with WAIT_CYCLES-1; WAIT->RESP when the counter equals 0.
REQ-018 RESP lasts exactly one cycle with rsp_valid=1, then ->IDLE; no request accepted in RESP.
REQ-019 Request-to-response latency: rsp_valid asserts WAIT_CYCLES+1 cycles after the accepting edge.
REQ-020 Memory is big-endian: word at A = {mem[A],mem[A+1],mem[A+2],mem[A+3]}; half at A = {mem[A],mem[A+1]}.
REQ-021 Store writes only the addressed bytes, on the edge leaving RESP; other bytes are unchanged.
REQ-022 Load data sampled from the array in RESP; rsp_rdata and rsp_err registered and held until next response.
REQ-023 Error when req_size=11, or when addr+size_bytes-1 >= MEM_BYTES (32-bit compare, no wrap); erroneous stores SHALL NOT modify memory.
REQ-024 req_valid deasserted or inputs changing after acceptance SHALL have no effect on the in-flight access.
REQ-025 Back-to-back: a new request may be accepted in the cycle after RESP (minimum issue interval WAIT_CYCLES+2).

Reset
REQ-026 While reset=1: state=IDLE, counter=0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, immediately (asynchronous).
REQ-027 Reset mid-operation aborts the access; a pending store SHALL NOT write memory; array contents are not cleared.

Configuration
REQ-028 Macro MEM_RESPONDER_ALIGN_CHECK_EN: when defined, halfword at odd address or word at address not multiple of 4 SHALL set rsp_err=1 with no memory effect; when undefined, misaligned accesses complete normally using REQ-020 byte ordering.

Verification
REQ-029 WAIT_CYCLES=1: store word 0xDEADBEEF @0x10, then load word @0x10 -> rsp_valid 2 cycles after each acceptance, rdata=0xDEADBEEF, err=0.
REQ-030 After REQ-029, store byte 0x55 @0x11, load word @0x10 -> rdata=0xDE55BEEF; load half @0x12 -> rdata=0x0000BEEF.
REQ-031 Load word @253 -> rsp_err=1, rdata=0; load byte @255 -> err=0; store word @0x100 -> err=1, memory @252..255 unchanged.
REQ-032 Assert reset one cycle after accepting store word 0x12345678 @0x20 (prior contents 0) -> outputs reset immediately; later load @0x20 returns 0x00000000.
REQ-033 Load half @0x11: with MEM_RESPONDER_ALIGN_CHECK_EN -> err=1; without -> err=0, rdata=0x000055BE; req_size=11 -> err=1 in both builds.
